// File: rtl/output_port_buffer.sv
// Output port buffer: small first-word-fall-through FIFO between the datapath
// output-instruction execute step and an external consumer.
// Optional feature macro: OUTPUT_PORT_DROP_CNT_EN adds an 8-bit saturating
// count of dropped writes (drop_cnt), cleared by reset and flush.
module output_port_buffer #(
  parameter int d     = 16,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [d-1:0]                   wr_data,
  input  logic                           flush,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [d-1:0]                   out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
`ifdef OUTPUT_PORT_DROP_CNT_EN
  output logic                           overflow,
  output logic [7:0]                     drop_cnt
`else
  output logic                           overflow
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [d-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          wr_acc;
  logic          drop;

  // Status flags and head word, all combinational from count and rd_ptr
  always_comb begin
    empty     = (count == '0);
    full      = (count == CW'(DEPTH));
    out_valid = ~empty;
    out_data  = mem[rd_ptr];
  end

  // Handshake decode: a full buffer can still accept when the head leaves
  always_comb begin
    pop    = out_valid & out_ready;
    wr_acc = wr_en & (~full | pop);
    drop   = wr_en & ~wr_acc;
  end

  // Storage write; no reset so the array keeps stale contents, which are
  // unreachable because the pointers restart at zero
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag, set by any dropped write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef OUTPUT_PORT_DROP_CNT_EN
  // Saturating dropped-write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (flush) begin
      drop_cnt <= 8'd0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_output_port_buffer.sv
// Testbench for output_port_buffer (d=16, DEPTH=4): table-driven vectors with
// explicit expectations plus a queue scoreboard that checks every popped word.
module tb_output_port_buffer;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
`ifdef OUTPUT_PORT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  output_port_buffer #(.d(16), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
`ifdef OUTPUT_PORT_DROP_CNT_EN
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
`else
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq[$];
  logic        m_ovf;
  int          m_drop;

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        rdy;
    logic        fl;
    int          ecount;
    logic        eovf;
    logic [15:0] ehead;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(mq.size()));
    check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(mq.size() == 4));
    check({tag, "_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) check({tag, "_head"}, 32'(out_data), 32'(mq[0]));
`ifdef OUTPUT_PORT_DROP_CNT_EN
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // One clock: drive at negedge, score pops before the edge, check after it
  task automatic step(input logic we, input logic [15:0] wd, input logic rdy, input logic fl);
    bit pre_full, pop, acc;
    @(negedge clk);
    wr_en     = we;
    wr_data   = we ? wd : 16'hzzzz;
    out_ready = rdy;
    flush     = fl;
    #1;
    pre_full = (mq.size() == 4);
    pop      = rdy && (mq.size() != 0);
    acc      = we && (!pre_full || pop);
    if (fl) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (pop) begin
        check("pop_data", 32'(out_data), 32'(mq[0]));
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(wd);
      else if (we) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    @(posedge clk);
    #1;
    check_state("step");
  endtask

  task automatic idle_inputs();
    wr_en     = 1'b0;
    wr_data   = 16'hzzzz;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    m_ovf  = 1'b0;
    m_drop = 0;
    idle_inputs();
    reset = 1'b1;

    // we, wd, rdy, fl, count, ovf, head
    vecs.push_back('{1'b1, 16'h1234, 1'b0, 1'b0, 1, 1'b0, 16'h1234});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 16'h0001, 1'b0, 1'b0, 1, 1'b0, 16'h0001});
    vecs.push_back('{1'b1, 16'h0002, 1'b0, 1'b0, 2, 1'b0, 16'h0001});
    vecs.push_back('{1'b1, 16'h0003, 1'b0, 1'b0, 3, 1'b0, 16'h0001});
    vecs.push_back('{1'b1, 16'h0004, 1'b0, 1'b0, 4, 1'b0, 16'h0001});
    vecs.push_back('{1'b1, 16'h0005, 1'b0, 1'b0, 4, 1'b1, 16'h0001});
    vecs.push_back('{1'b1, 16'h00AA, 1'b1, 1'b0, 4, 1'b1, 16'h0002});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b1, 16'h0003});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b1, 16'h0004});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 16'h00AA});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 16'h0077, 1'b1, 1'b0, 1, 1'b0, 16'h0077});

    #2;
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].rdy, vecs[i].fl);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecount));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eovf));
      if (vecs[i].ecount != 0)
        check($sformatf("vec%0d_head", i), 32'(out_data), 32'(vecs[i].ehead));
    end

    // Streaming across pointer wrap with the consumer always ready
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("stream_ovf", 32'(overflow), 32'd0);
    check("stream_empty", 32'(empty), 32'd1);

    // Reset pulsed between edges with three words stored
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #2;
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_count", 32'(count), 32'd0);
    #1;
    reset = 1'b0;
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("after_rst_head", 32'(out_data), 32'h0000BEEF);

    // Floating data bus with no strobe leaves everything untouched
    step(1'b1, 16'h0C01, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    check("z_count", 32'(count), 32'd2);
    check("z_head", 32'(out_data), 32'h0000BEEF);

    // Overflow while full, then flush clears words and flag
    step(1'b1, 16'h0C02, 1'b0, 1'b0);
    step(1'b1, 16'h0C03, 1'b0, 1'b0);
    step(1'b1, 16'h0C04, 1'b0, 1'b0);
    check("ovf2_flag", 32'(overflow), 32'd1);
    step(1'b1, 16'h0C05, 1'b1, 1'b1);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);

    // Drain with ready while empty: nothing happens
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("idle_ready_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_port_buffer.md
OUTPUT_PORT_BUFFER -- requirements
Module: output_port_buffer

Interface
REQ-001 Parameter d, default 16, data word width; SHALL match the datapath output word width.
REQ-002 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; SHALL clear all state immediately, independent of clk.
REQ-005 wr_en  input  1  write strobe, high for one cycle per datapath output-instruction execute step.
REQ-006 wr_data  input  d  output word (datapath cu_data); SHALL be sampled only when wr_en=1, so Z values while wr_en=0 are ignored.
REQ-007 flush  input  1  synchronous clear of buffered words.
REQ-008 out_ready  input  1  consumer accepts the word when high.
REQ-009 out_valid  output  1  head word present.
REQ-010 out_data  output  d  head word, first-word-fall-through.
REQ-011 count  output  $clog2(DEPTH+1)  number of stored words.
REQ-012 full  output  1  count==DEPTH.
REQ-013 empty  output  1  count==0.
REQ-014 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-015 Write accepted iff wr_en=1 and (full=0 or pop occurs the same cycle); word stored at wr_ptr, wr_ptr+1 mod DEPTH.
REQ-016 Pop occurs iff out_valid=1 and out_ready=1; rd_ptr+1 mod DEPTH.
REQ-017 out_valid SHALL equal ~empty; out_data SHALL equal mem[rd_ptr] combinationally; out_data is don't-care when empty.
REQ-018 Latency: a word written at edge N SHALL appear on out_data/out_valid after edge N when the buffer was empty.
REQ-019 Order SHALL be strictly FIFO; pointers wrap without loss.
REQ-020 Simultaneous accepted write and pop: count unchanged; when full, the freed slot SHALL take the new word.
REQ-021 Simultaneous write and pop when empty: no pop (out_valid=0); write accepted; count becomes 1.
REQ-022 wr_en=1 while full with no pop: word dropped, state unchanged, overflow set to 1 at that edge.
REQ-023 out_ready=1 while empty: no effect.
REQ-024 flush=1: pointers and count SHALL go to 0 at the edge; concurrent write and pop ignored; overflow SHALL be cleared.
REQ-025 count SHALL change by at most 1 per cycle and never exceed DEPTH.

Reset
REQ-026 On reset=1: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out_valid=0, overflow=0; storage array not cleared.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered words; the first write after reset release lands in slot 0.
REQ-028 No write or pop SHALL take effect on an edge where reset=1.

Configuration
REQ-029 Macro OUTPUT_PORT_DROP_CNT_EN: when defined, adds output drop_cnt [7:0], counting dropped writes and saturating at 255, cleared by reset and flush.
REQ-030 When OUTPUT_PORT_DROP_CNT_EN is undefined, drop_cnt SHALL not exist; all other behaviour SHALL be identical.

Verification (d=16, DEPTH=4)
REQ-031 Reset, then wr_en with 0x1234, out_ready=0 -> next cycle out_valid=1, out_data=0x1234, count=1.
REQ-032 Writes 0x0001..0x0004, out_ready=0 -> full=1, count=4; write 0x0005 -> dropped, overflow=1, count=4 (with macro: drop_cnt=1).
REQ-033 Full, wr_en with 0x00AA and out_ready=1 on the same cycle -> 0x0001 popped, count stays 4, later drain order 0x0002,0x0003,0x0004,0x00AA.
REQ-034 Ten writes interleaved with pops, out_ready held 1 -> output sequence equals input sequence across pointer wrap; no overflow.
REQ-035 Three words stored, reset pulsed between edges -> empty=1, count=0 immediately; next write 0xBEEF appears as head.
REQ-036 wr_data=Z with wr_en=0 for 20 cycles -> count, pointers and overflow unchanged; flush with 2 words stored -> empty=1 next edge.
